seq_player: RTL and testbench

SEQ_PLAYER -- requirements
Module: seq_player

---
 rtl/seq_player_pkg.sv | 30 +++
 rtl/seq_player_timer.sv | 48 ++++
 rtl/seq_player.sv | 190 +++++++++++++++++++
 tb/tb_seq_player.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seq_player_pkg.sv
// -----------------------------------------------------------------------------
// seq_player_pkg
// Shared definitions for the colour sequence player:
//   - state_e : player FSM state encoding (IDLE=0, SHOW=1, GAP=2, FINISH=3)
//   - color_e : colour codes presented to the external 4:1 colour mux
//   - step_color() : extracts the 2-bit colour of one step from the 32-bit
//                    colour memory (step k lives in bits [2k+1:2k])
// -----------------------------------------------------------------------------
package seq_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLR_0 = 2'd0,
    CLR_1 = 2'd1,
    CLR_2 = 2'd2,
    CLR_3 = 2'd3
  } color_e;

  // Colour code of step 'step' inside the packed colour memory.
  function automatic color_e step_color(input logic [31:0] seq, input logic [3:0] step);
    return color_e'(seq[{step, 1'b0} +: 2]);
  endfunction

endpackage

// File: rtl/seq_player_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
// Loadable down-counter with a zero flag. A load takes priority over counting;
// the counter stops at zero and stays there until the next load.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset (count forced to 0)
//   load_i     : load load_val_i this cycle
//   load_val_i : value loaded (cycles remaining minus one)
//   zero_o     : count is zero
// -----------------------------------------------------------------------------
module seq_timer #(
  parameter int TW = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          zero_o
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: load, else decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {TW{1'b0}}) begin
      cnt_d = cnt_q - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {TW{1'b0}};
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {TW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {TW{1'b0}});

endmodule

// File: rtl/seq_player.sv
// -----------------------------------------------------------------------------
// seq_player
// Plays a sequence of up to 16 colours: each step shows its colour for
// ON_CYCLES cycles (LED_EN=1) followed by OFF_CYCLES blank cycles, then a
// one-cycle DONE pulse. LEN and SEQ are latched when START is accepted in IDLE.
// All outputs are registered, decoded from the next state.
// Optional feature: define SEQ_PLAYER_ABORT_EN to add the ABORT input, which
// returns any active playback to IDLE on the next cycle without DONE.
// Ports:
//   CLOCK  : clock, rising edge
//   RESET  : synchronous active-high reset
//   START  : play request, honoured only in IDLE
//   LEN    : index of the last step (0..15)
//   SEQ    : colour memory, step k = SEQ[2k+1:2k]
//   ABORT  : (SEQ_PLAYER_ABORT_EN only) cancel playback
//   SEL    : colour select for the external 4:1 mux
//   LED_EN : colour is being displayed
//   STEP   : index of the step being played
//   BUSY   : not in IDLE
//   DONE   : one-cycle pulse at the end of playback
// -----------------------------------------------------------------------------
module seq_player
  import seq_player_pkg::*;
#(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic [3:0]  LEN,
  input  logic [31:0] SEQ,
`ifdef SEQ_PLAYER_ABORT_EN
  input  logic        ABORT,
`endif
  output logic [1:0]  SEL,
  output logic        LED_EN,
  output logic [3:0]  STEP,
  output logic        BUSY,
  output logic        DONE
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  // Timer holds "cycles remaining minus one" so a phase ends when it hits zero.
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  state_e        state_q, state_d, play_state_s;
  logic [3:0]    step_q, step_d;
  logic [3:0]    len_q, len_d;
  logic [31:0]   seq_q, seq_d;
  logic [1:0]    sel_q, sel_d;
  logic          led_en_q, led_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_s, play_load_s;
  logic [TW-1:0] load_val_s, play_load_val_s;
  logic          tmr_zero_s;
  logic          abort_s;

`ifdef SEQ_PLAYER_ABORT_EN
  assign abort_s = ABORT;
`else
  assign abort_s = 1'b0;
`endif

  seq_timer #(
    .TW (TW)
  ) u_timer (
    .clk_i      (CLOCK),
    .rst_i      (RESET),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .zero_o     (tmr_zero_s)
  );

  // Playback FSM next state, latched operands and timer reloads.
  always_comb begin
    play_state_s    = state_q;
    play_load_s     = 1'b0;
    play_load_val_s = {TW{1'b0}};
    step_d          = step_q;
    len_d           = len_q;
    seq_d           = seq_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          len_d           = LEN;
          seq_d           = SEQ;
          step_d          = 4'd0;
          play_state_s    = ST_SHOW;
          play_load_s     = 1'b1;
          play_load_val_s = ON_LOAD;
        end else begin
          play_state_s = ST_IDLE;
        end
      end
      ST_SHOW: begin
        if (tmr_zero_s) begin
          play_state_s    = ST_GAP;
          play_load_s     = 1'b1;
          play_load_val_s = OFF_LOAD;
        end else begin
          play_state_s = ST_SHOW;
        end
      end
      ST_GAP: begin
        if (!tmr_zero_s) begin
          play_state_s = ST_GAP;
        end else if (step_q == len_q) begin
          // Compare before incrementing so LEN=15 never wraps STEP.
          play_state_s    = ST_FINISH;
          play_load_s     = 1'b1;
          play_load_val_s = {TW{1'b0}};
        end else begin
          step_d          = step_q + 4'd1;
          play_state_s    = ST_SHOW;
          play_load_s     = 1'b1;
          play_load_val_s = ON_LOAD;
        end
      end
      ST_FINISH: begin
        play_state_s    = ST_IDLE;
        play_load_s     = 1'b1;
        play_load_val_s = {TW{1'b0}};
      end
      default: begin
        play_state_s    = ST_IDLE;
        play_load_s     = 1'b1;
        play_load_val_s = {TW{1'b0}};
      end
    endcase
  end

  // Abort override and registered-output next values.
  always_comb begin
    state_d    = play_state_s;
    load_s     = play_load_s;
    load_val_s = play_load_val_s;
    if (abort_s && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      load_s     = 1'b1;
      load_val_s = {TW{1'b0}};
    end else begin
      state_d    = play_state_s;
      load_s     = play_load_s;
      load_val_s = play_load_val_s;
    end
    led_en_d = (state_d == ST_SHOW);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_FINISH);
    // SEL follows the active step and freezes once playback leaves SHOW/GAP.
    if ((state_d == ST_SHOW) || (state_d == ST_GAP)) begin
      sel_d = step_color(seq_d, step_d);
    end else begin
      sel_d = sel_q;
    end
  end

  // State, latched operands and output registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      step_q   <= 4'd0;
      len_q    <= 4'd0;
      seq_q    <= 32'd0;
      sel_q    <= 2'd0;
      led_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      len_q    <= len_d;
      seq_q    <= seq_d;
      sel_q    <= sel_d;
      led_en_q <= led_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign SEL    = sel_q;
  assign LED_EN = led_en_q;
  assign STEP   = step_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_seq_player.sv
// -----------------------------------------------------------------------------
// tb_seq_player
// Directed self-checking bench for seq_player with ON_CYCLES=4, OFF_CYCLES=2.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_seq_player;

  localparam int ON  = 4;
  localparam int OFF = 2;

  logic        CLOCK;
  logic        RESET;
  logic        START;
  logic [3:0]  LEN;
  logic [31:0] SEQ;
`ifdef SEQ_PLAYER_ABORT_EN
  logic        ABORT;
`endif
  logic [1:0]  SEL;
  logic        LED_EN;
  logic [3:0]  STEP;
  logic        BUSY;
  logic        DONE;

  int n_checks = 0;
  int n_errors = 0;

  seq_player #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .START  (START),
    .LEN    (LEN),
    .SEQ    (SEQ),
`ifdef SEQ_PLAYER_ABORT_EN
    .ABORT  (ABORT),
`endif
    .SEL    (SEL),
    .LED_EN (LED_EN),
    .STEP   (STEP),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one playback and checks every output each cycle.
  // exp_done: cycle of the DONE pulse after START (-1 = none).
  // restart_k / chg_k / rst_k / abort_k: cycle in which START is pulsed again,
  // SEQ/LEN are scrambled, RESET or ABORT is asserted (0 = never).
  task automatic run_check(input int id, input logic [3:0] len, input logic [31:0] seq,
                           input int exp_done, input int restart_k, input int chg_k,
                           input int rst_k, input int abort_k);
    int total, cut, limit, first_done, ndone, st, ph;
    logic [1:0] last_sel;
    total      = (int'(len) + 1) * (ON + OFF);
    cut        = (rst_k > 0) ? rst_k : abort_k;
    limit      = (cut > 0) ? cut + 20 : total + 2;
    first_done = -1;
    ndone      = 0;
    last_sel   = seq[2*int'(len) +: 2];
    @(negedge CLOCK);
    START = 1'b1;
    LEN   = len;
    SEQ   = seq;
    @(negedge CLOCK);
    START = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (DONE) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      if ((cut > 0) && (k > cut)) begin
        chk($sformatf("r%0d_busy_k%0d", id, k), 32'(BUSY), 32'd0);
        chk($sformatf("r%0d_led_k%0d", id, k), 32'(LED_EN), 32'd0);
        chk($sformatf("r%0d_done_k%0d", id, k), 32'(DONE), 32'd0);
        if (rst_k > 0) begin
          chk($sformatf("r%0d_sel_k%0d", id, k), 32'(SEL), 32'd0);
          chk($sformatf("r%0d_step_k%0d", id, k), 32'(STEP), 32'd0);
        end
      end else if (k <= total) begin
        st = (k - 1) / (ON + OFF);
        ph = (k - 1) % (ON + OFF);
        chk($sformatf("r%0d_busy_k%0d", id, k), 32'(BUSY), 32'd1);
        chk($sformatf("r%0d_led_k%0d", id, k), 32'(LED_EN), 32'(ph < ON));
        chk($sformatf("r%0d_sel_k%0d", id, k), 32'(SEL), 32'(seq[2*st +: 2]));
        chk($sformatf("r%0d_step_k%0d", id, k), 32'(STEP), 32'(st));
        chk($sformatf("r%0d_done_k%0d", id, k), 32'(DONE), 32'd0);
      end else if (k == total + 1) begin
        chk($sformatf("r%0d_busy_k%0d", id, k), 32'(BUSY), 32'd1);
        chk($sformatf("r%0d_led_k%0d", id, k), 32'(LED_EN), 32'd0);
        chk($sformatf("r%0d_done_k%0d", id, k), 32'(DONE), 32'd1);
        chk($sformatf("r%0d_sel_k%0d", id, k), 32'(SEL), 32'(last_sel));
        chk($sformatf("r%0d_step_k%0d", id, k), 32'(STEP), 32'(len));
      end else begin
        chk($sformatf("r%0d_busy_k%0d", id, k), 32'(BUSY), 32'd0);
        chk($sformatf("r%0d_led_k%0d", id, k), 32'(LED_EN), 32'd0);
        chk($sformatf("r%0d_done_k%0d", id, k), 32'(DONE), 32'd0);
        chk($sformatf("r%0d_sel_k%0d", id, k), 32'(SEL), 32'(last_sel));
        chk($sformatf("r%0d_step_k%0d", id, k), 32'(STEP), 32'(len));
      end
      START = (k == restart_k);
      if (k == chg_k) begin
        SEQ = ~seq;
        LEN = ~len;
      end
      RESET = (k == rst_k);
`ifdef SEQ_PLAYER_ABORT_EN
      ABORT = (k == abort_k);
`endif
      @(negedge CLOCK);
    end
    chk($sformatf("r%0d_done_at", id), 32'(first_done), 32'(exp_done));
    chk($sformatf("r%0d_done_cnt", id), 32'(ndone), (exp_done < 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    LEN   = 4'd0;
    SEQ   = 32'd0;
`ifdef SEQ_PLAYER_ABORT_EN
    ABORT = 1'b0;
`endif
    repeat (2) @(negedge CLOCK);
    chk("rst_sel", 32'(SEL), 32'd0);
    chk("rst_led", 32'(LED_EN), 32'd0);
    chk("rst_step", 32'(STEP), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);

    // RESET wins over a simultaneous START.
    START = 1'b1;
    LEN   = 4'd3;
    SEQ   = 32'h0000_00E4;
    @(negedge CLOCK);
    START = 1'b0;
    RESET = 1'b0;
    chk("rst_prio_busy", 32'(BUSY), 32'd0);
    chk("rst_prio_led", 32'(LED_EN), 32'd0);
    @(negedge CLOCK);
    chk("rst_prio_busy2", 32'(BUSY), 32'd0);

    // Single step, colour 2.
    run_check(1, 4'd0, 32'h0000_0002, 7, 0, 0, 0, 0);
    // Four steps, colours 0,1,2,3.
    run_check(2, 4'd3, 32'h0000_00E4, 25, 0, 0, 0, 0);
    // All 16 steps, no STEP wrap.
    run_check(3, 4'd15, 32'hFFFF_FFFF, 97, 0, 0, 0, 0);
    // Restart at t+3 and SEQ/LEN change at t+5 have no effect.
    run_check(4, 4'd0, 32'h0000_0002, 7, 3, 5, 0, 0);
    // Reset at t+10 of a four-step run, then a normal run.
    run_check(5, 4'd3, 32'h0000_00E4, -1, 0, 0, 10, 0);
    run_check(6, 4'd1, 32'h0000_0006, 13, 0, 0, 0, 0);
`ifdef SEQ_PLAYER_ABORT_EN
    // Abort at t+6 of a four-step run.
    run_check(7, 4'd3, 32'h0000_00E4, -1, 0, 0, 0, 6);
    run_check(8, 4'd0, 32'h0000_0001, 7, 0, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
